// File: rtl/regbank_pkg.sv
// Shared widths, the hard-wired zero register index and the writeback requester encoding.
package regbank_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 0;

  // Bit position of each writeback source in the req/gnt vectors
  typedef enum logic {
    ReqAlu  = 1'b0,
    ReqLoad = 1'b1
  } req_idx_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on contention.
module rr_arb2
  import regbank_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_idx_e ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (!rst) begin
      if (req == 2'b11) begin
        unique case (ptr_q)
          ReqAlu:  gnt = 2'b01;
          ReqLoad: gnt = 2'b10;
          default: gnt = 2'b01;
        endcase
      end else begin
        gnt = req;
      end
      // The winner always hands priority to the other side
      if (gnt[ReqAlu]) begin
        ptr_d = ReqLoad;
      end else if (gnt[ReqLoad]) begin
        ptr_d = ReqAlu;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= ReqAlu;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Arbitrates ALU and load writebacks onto the single regbank write port, with read bypass.
module regbank_wr_arbiter #(
  parameter int unsigned DATA_W = regbank_pkg::DATA_W,
  parameter int unsigned ADDR_W = regbank_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_req,
  input  logic [ADDR_W-1:0] wb0_reg,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_gnt,
  input  logic              wb1_req,
  input  logic [ADDR_W-1:0] wb1_reg,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_gnt,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [DATA_W-1:0] rb_data1,
  input  logic [DATA_W-1:0] rb_data2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [15:0]       conflict_cnt
);

  import regbank_pkg::*;

  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(ZERO_REG);

  logic [1:0]        req, gnt;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [15:0]       cnt_q, cnt_d;

  assign req = {wb1_req, wb0_req};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign wb0_gnt  = gnt[ReqAlu];
  assign wb1_gnt  = gnt[ReqLoad];
  assign sel_reg  = gnt[ReqLoad] ? wb1_reg  : wb0_reg;
  assign sel_data = gnt[ReqLoad] ? wb1_data : wb0_data;

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    // Writes to the zero register are accepted but never reach the regbank
    if (|gnt) begin
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
      reg_write_d  = (sel_reg != ZeroIdx);
    end
    cnt_d = cnt_q;
    if ((&req) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    read_data1 = rb_data1;
    if (read_reg1 == ZeroIdx) begin
      read_data1 = '0;
    end else if (reg_write_q && (write_reg_q == read_reg1)) begin
      read_data1 = write_data_q;
    end
  end

  always_comb begin
    read_data2 = rb_data2;
    if (read_reg2 == ZeroIdx) begin
      read_data2 = '0;
    end else if (reg_write_q && (write_reg_q == read_reg2)) begin
      read_data2 = write_data_q;
    end
  end

  assign reg_write    = reg_write_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Scenario bench for regbank_wr_arbiter: a reference model queues the expected write-port
// state per cycle and a monitor compares it one edge later.
module tb_regbank_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        wb0_req, wb1_req;
  logic [4:0]  wb0_reg, wb1_reg;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_gnt, wb1_gnt;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] rb_data1, rb_data2;
  logic [31:0] read_data1, read_data2;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic        chk;
    logic [4:0]  r;
    logic [31:0] d;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        m_ptr;
  logic [15:0] m_cnt;

  regbank_wr_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .wb0_req      (wb0_req),
    .wb0_reg      (wb0_reg),
    .wb0_data     (wb0_data),
    .wb0_gnt      (wb0_gnt),
    .wb1_req      (wb1_req),
    .wb1_reg      (wb1_reg),
    .wb1_data     (wb1_data),
    .wb1_gnt      (wb1_gnt),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .rb_data1     (rb_data1),
    .rb_data2     (rb_data2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: each entry was pushed during the previous cycle
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (reg_write !== mon_e.we) begin
        errors++;
        $display("FAIL sb_reg_write got %0b want %0b at %0t", reg_write, mon_e.we, $time);
      end
      checks++;
      if (conflict_cnt !== mon_e.cnt) begin
        errors++;
        $display("FAIL sb_conflict_cnt got %0h want %0h at %0t", conflict_cnt, mon_e.cnt, $time);
      end
      if (mon_e.chk) begin
        checks++;
        if (write_reg !== mon_e.r || write_data !== mon_e.d) begin
          errors++;
          $display("FAIL sb_write got %0h/%0h want %0h/%0h at %0t",
                   write_reg, write_data, mon_e.r, mon_e.d, $time);
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Waits for mid-cycle, returns the model's grant and queues the next-cycle write state
  task automatic tick(output logic [1:0] eg);
    exp_t e;
    @(negedge clk);
    e.we  = 1'b0;
    e.chk = 1'b0;
    e.r   = '0;
    e.d   = '0;
    if (rst) begin
      eg    = 2'b00;
      m_ptr = 1'b0;
      m_cnt = '0;
      e.chk = 1'b1;
    end else begin
      if (wb0_req && wb1_req) begin
        eg = m_ptr ? 2'b10 : 2'b01;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        eg = {wb1_req, wb0_req};
      end
      if (eg[0]) m_ptr = 1'b1;
      else if (eg[1]) m_ptr = 1'b0;
      if (eg != 2'b00) begin
        e.chk = 1'b1;
        e.r   = eg[1] ? wb1_reg : wb0_reg;
        e.d   = eg[1] ? wb1_data : wb0_data;
        e.we  = (e.r != 5'd0);
      end
    end
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    wb0_req = 1'b0; wb0_reg = '0; wb0_data = '0;
    wb1_req = 1'b0; wb1_reg = '0; wb1_data = '0;
  endtask

  task automatic do_reset();
    logic [1:0] eg;
    rst = 1'b1;
    tick(eg);
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] eg;
    rst = 1'b1;
    wb0_req = 1'b1; wb0_reg = 5'h03; wb0_data = 32'h0BAD0BAD;
    wb1_req = 1'b1; wb1_reg = 5'h06; wb1_data = 32'h0BADF00D;
    for (int i = 0; i < 2; i++) begin
      tick(eg);
      checks++;
      if ({wb1_gnt, wb0_gnt} !== 2'b00) begin
        errors++;
        $display("FAIL reset_gnt got %b want 00", {wb1_gnt, wb0_gnt});
      end
      adv();
    end
    checks++;
    if (reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 || conflict_cnt !== 16'd0)
    begin
      errors++;
      $display("FAIL reset_outputs got %b/%h/%h/%h want 0/0/0/0",
               reg_write, write_reg, write_data, conflict_cnt);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    logic [1:0] eg;
    wb0_req = 1'b1; wb0_reg = 5'h04; wb0_data = 32'hDEADBEEF;
    tick(eg);
    checks++;
    if ({wb1_gnt, wb0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL single_gnt got %b want 01", {wb1_gnt, wb0_gnt});
    end
    adv();
    idle_inputs();
    tick(eg);
    checks++;
    if (reg_write !== 1'b1 || write_reg !== 5'h04 || write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write got %b/%h/%h want 1/04/deadbeef", reg_write, write_reg, write_data);
    end
    adv();
  endtask

  task automatic test_contention();
    logic [1:0] eg;
    logic [1:0] pat [4];
    pat = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    wb0_req = 1'b1; wb1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb0_reg = 5'(i + 1);  wb0_data = 32'hA000_0000 + 32'(i);
      wb1_reg = 5'(i + 17); wb1_data = 32'hB000_0000 + 32'(i);
      tick(eg);
      checks++;
      if ({wb1_gnt, wb0_gnt} !== pat[i]) begin
        errors++;
        $display("FAIL contention_gnt[%0d] got %b want %b", i, {wb1_gnt, wb0_gnt}, pat[i]);
      end
      adv();
    end
    checks++;
    if (conflict_cnt !== 16'd4) begin
      errors++;
      $display("FAIL contention_cnt got %0d want 4", conflict_cnt);
    end
    idle_inputs();
    tick(eg);
    adv();
  endtask

  task automatic test_bypass();
    logic [1:0] eg;
    wb1_req = 1'b1; wb1_reg = 5'h0D; wb1_data = 32'h12345678;
    read_reg1 = 5'h0D; rb_data1 = 32'hAAAA5555;
    read_reg2 = 5'h03; rb_data2 = 32'h00000077;
    tick(eg);
    checks++;
    if ({wb1_gnt, wb0_gnt} !== 2'b10 || read_data1 !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL bypass_grant got %b/%h want 10/aaaa5555", {wb1_gnt, wb0_gnt}, read_data1);
    end
    adv();
    idle_inputs();
    tick(eg);
    checks++;
    if (read_data1 !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_hit got %h want 12345678", read_data1);
    end
    checks++;
    if (read_data2 !== 32'h00000077) begin
      errors++;
      $display("FAIL bypass_miss got %h want 00000077", read_data2);
    end
    adv();
    tick(eg);
    checks++;
    if (read_data1 !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL bypass_expired got %h want aaaa5555", read_data1);
    end
    adv();
  endtask

  task automatic test_zero_reg();
    logic [1:0] eg;
    wb0_req = 1'b1; wb0_reg = 5'h00; wb0_data = 32'hFFFFFFFF;
    read_reg1 = 5'h00; rb_data1 = 32'h00001234;
    read_reg2 = 5'h00; rb_data2 = 32'h5A5A5A5A;
    tick(eg);
    checks++;
    if ({wb1_gnt, wb0_gnt} !== 2'b01 || read_data2 !== 32'd0) begin
      errors++;
      $display("FAIL zero_grant got %b/%h want 01/00000000", {wb1_gnt, wb0_gnt}, read_data2);
    end
    adv();
    idle_inputs();
    tick(eg);
    checks++;
    if (reg_write !== 1'b0 || read_data2 !== 32'd0 || read_data1 !== 32'd0) begin
      errors++;
      $display("FAIL zero_write got %b/%h/%h want 0/0/0", reg_write, read_data1, read_data2);
    end
    adv();
  endtask

  task automatic test_same_reg();
    logic [1:0]  eg;
    logic        first;
    logic [31:0] later;
    first = m_ptr;
    later = first ? 32'h11111111 : 32'h22222222;
    wb0_req = 1'b1; wb0_reg = 5'h07; wb0_data = 32'h11111111;
    wb1_req = 1'b1; wb1_reg = 5'h07; wb1_data = 32'h22222222;
    tick(eg);
    checks++;
    if ({wb1_gnt, wb0_gnt} !== eg) begin
      errors++;
      $display("FAIL same_first_gnt got %b want %b", {wb1_gnt, wb0_gnt}, eg);
    end
    adv();
    if (first) wb1_req = 1'b0;
    else wb0_req = 1'b0;
    tick(eg);
    checks++;
    if ({wb1_gnt, wb0_gnt} !== (first ? 2'b01 : 2'b10)) begin
      errors++;
      $display("FAIL same_second_gnt got %b want %b", {wb1_gnt, wb0_gnt}, first ? 2'b01 : 2'b10);
    end
    adv();
    idle_inputs();
    tick(eg);
    checks++;
    if (reg_write !== 1'b1 || write_reg !== 5'h07 || write_data !== later) begin
      errors++;
      $display("FAIL same_final got %b/%h/%h want 1/07/%h", reg_write, write_reg, write_data, later);
    end
    adv();
  endtask

  task automatic test_reset_drop();
    logic [1:0] eg;
    wb0_req = 1'b1; wb0_reg = 5'h09; wb0_data = 32'h99999999;
    tick(eg);
    checks++;
    if ({wb1_gnt, wb0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rstdrop_gnt got %b want 01", {wb1_gnt, wb0_gnt});
    end
    adv();
    idle_inputs();
    rst = 1'b1;
    wb1_req = 1'b1; wb1_reg = 5'h0A; wb1_data = 32'hAAAAAAAA;
    tick(eg);
    checks++;
    if ({wb1_gnt, wb0_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL rstdrop_gnt_in_reset got %b want 00", {wb1_gnt, wb0_gnt});
    end
    adv();
    rst = 1'b0;
    idle_inputs();
    read_reg1 = 5'h00; read_reg2 = 5'h00;
    checks++;
    if (reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 ||
        conflict_cnt !== 16'd0 || read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
      errors++;
      $display("FAIL rstdrop_outputs got %b/%h/%h/%h/%h/%h want all 0",
               reg_write, write_reg, write_data, conflict_cnt, read_data1, read_data2);
    end
    wb0_req = 1'b1; wb0_reg = 5'h01; wb0_data = 32'h01010101;
    wb1_req = 1'b1; wb1_reg = 5'h02; wb1_data = 32'h02020202;
    tick(eg);
    checks++;
    if ({wb1_gnt, wb0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rstdrop_first_after got %b want 01", {wb1_gnt, wb0_gnt});
    end
    adv();
    idle_inputs();
    tick(eg);
    adv();
  endtask

  task automatic test_saturate();
    logic [1:0] eg;
    int         bad;
    bad = 0;
    do_reset();
    wb0_req = 1'b1; wb0_reg = 5'h05; wb0_data = 32'h55555555;
    wb1_req = 1'b1; wb1_reg = 5'h06; wb1_data = 32'h66666666;
    for (int i = 0; i < 70000; i++) begin
      tick(eg);
      if ({wb1_gnt, wb0_gnt} !== eg) bad++;
      adv();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL saturate_gnt got %0d bad grants want 0", bad);
    end
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate_cnt got %h want ffff", conflict_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick(eg);
      adv();
    end
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate_hold got %h want ffff", conflict_cnt);
    end
    idle_inputs();
    tick(eg);
    adv();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    read_reg1 = '0; read_reg2 = '0;
    rb_data1 = '0;  rb_data2 = '0;
    m_ptr = 1'b0;
    m_cnt = '0;
    adv();
    test_reset();
    test_single();
    test_contention();
    test_bypass();
    test_zero_reg();
    test_same_reg();
    test_reset_drop();
    test_saturate();
    adv();
    adv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_wr_arbiter.md
REGBANK_WR_ARBITER -- requirements
Module: regbank_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register index width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-005 Ports wb0_req / wb1_req, input, 1, SHALL carry the write requests from the ALU writeback (0) and the load writeback (1).
REQ-006 Ports wb0_reg / wb1_reg, input, ADDR_W, SHALL carry the destination register index of each request.
REQ-007 Ports wb0_data / wb1_data, input, DATA_W, SHALL carry the write data of each request.
REQ-008 Ports wb0_gnt / wb1_gnt, output, 1, SHALL indicate the request was accepted this cycle.
REQ-009 Ports reg_write, write_reg, write_data, output, 1/ADDR_W/DATA_W, SHALL drive the regbank write port.
REQ-010 Ports read_reg1 / read_reg2, input, ADDR_W, SHALL carry the read indices, also sent to the regbank.
REQ-011 Ports rb_data1 / rb_data2, input, DATA_W, SHALL carry the raw regbank read data.
REQ-012 Ports read_data1 / read_data2, output, DATA_W, SHALL carry the bypassed read data.
REQ-013 Port conflict_cnt, output, 16, SHALL count cycles with both requests asserted.

Function
REQ-014 A request SHALL be accepted in the cycle its gnt is high; gnt SHALL be combinational from req and the priority pointer, and at most one gnt SHALL be high per cycle.
REQ-015 A requester SHALL hold req, reg and data stable until its gnt is seen; the arbiter SHALL NOT buffer ungranted requests.
REQ-016 With a single request, that requester SHALL be granted and the priority pointer SHALL move to the other requester.
REQ-017 With both requesting, the requester named by the priority pointer SHALL be granted and the pointer SHALL toggle.
REQ-018 With no request, the pointer SHALL hold and reg_write SHALL be 0 next cycle.
REQ-019 The granted reg and data SHALL be registered onto write_reg and write_data one cycle after the grant (latency 1).
REQ-020 reg_write SHALL be 1 in that cycle, except for register index 0, which SHALL still be granted with reg_write held at 0.
REQ-021 read_dataN SHALL equal write_data when reg_write=1, write_reg==read_regN and read_regN!=0; otherwise it SHALL equal rb_dataN.
REQ-022 read_dataN SHALL be 0 whenever read_regN==0, regardless of rb_dataN.
REQ-023 conflict_cnt SHALL increment in each cycle both requests are high and SHALL saturate at 16'hFFFF.
REQ-024 When both requests target the same register, both SHALL be written in grant order, so the later-granted data persists.

Reset
REQ-025 While rst=1, wb0_gnt and wb1_gnt SHALL be 0.
REQ-026 At the clock edge with rst=1: reg_write=0, write_reg=0, write_data=0, conflict_cnt=0, and the pointer SHALL favour requester 0.
REQ-027 A registered write pending at the reset edge SHALL be dropped; no regbank write SHALL occur in the cycle after reset.

Structure
REQ-028 Package regbank_pkg SHALL hold DATA_W, ADDR_W, the ZERO_REG constant (0) and the requester-index encoding.
REQ-029 The two-way round-robin grant logic SHALL be a sub-module named rr_arb2, with inputs req[1:0] and outputs gnt[1:0], holding the pointer internally.
REQ-030 The top level SHALL contain only the output register stage, the bypass muxes and conflict_cnt.

Verification
REQ-031 After reset, wb0_req=1, reg=5'h04, data=32'hDEADBEEF -> wb0_gnt=1 at once; next cycle reg_write=1, write_reg=4, write_data=DEADBEEF.
REQ-032 Both requests held for 4 cycles from reset -> grants alternate 0,1,0,1 and conflict_cnt=4.
REQ-033 wb1 writes reg 5'h0D with 32'h12345678 while read_reg1=5'h0D -> in the reg_write cycle, read_data1=12345678 while rb_data1 still holds the old value.
REQ-034 wb0 writes reg 0 with 32'hFFFFFFFF and read_reg2=0 -> wb0_gnt=1, reg_write stays 0 and read_data2=0.
REQ-035 rst asserted in the cycle after a grant -> no reg_write, all outputs 0, and after release a contention grants requester 0 first.
REQ-036 Both requests held for 70000 cycles -> conflict_cnt=16'hFFFF and stays there.
